num_accu_vec: RTL
=================

Name: num_accu_vec

Overview:
- Parametrised, pipelined successor to the scalar per-beat accumulator.
- Reduces a full cache line of LANES = CACHE_WIDTH/DATA_WIDTH unsigned elements per accepted beat, then accumulates across a group of size_out lines.
- Emits one result per group through a valid/ready output.
- Selectable reduction mode (sum/min/max/xor) and a global-stall backpressure scheme; sits between the CCI-E read-response path and the result writer.

Parameters:
- CACHE_WIDTH, 512, input line width in bits.
- DATA_WIDTH, 32, element width; CACHE_WIDTH/DATA_WIDTH must be a power of 2 and at least 2.
- ACC_WIDTH, 48, accumulator/result width; must be at least DATA_WIDTH.
- CNT_WIDTH, 32, width of group-length field and line counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- size_out  in  CNT_WIDTH  lines per group; sampled on first beat of each group; 0 treated as 1.
- mode  in  2  00 sum, 01 min, 10 max, 11 xor; sampled with size_out.
- in_valid  in  1  in_data valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  CACHE_WIDTH  LANES elements; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_res/out_cnt valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_res  out  ACC_WIDTH  group reduction result.
- out_cnt  out  CNT_WIDTH  lines reduced into this result.

Behaviour:
- Reset: out_valid=0, out_res=0, out_cnt=0, in_ready=0 during the reset cycle. Pipeline valids, line counter and accumulator are cleared. Reset mid-group discards the partial group and any in-flight beats, with no output.
- Stall signal: stall = out_valid && !out_ready.
  - in_ready = !stall && !rst.
  - When stall is high, every pipeline register holds.
  - Simultaneous out handshake and new in beat in the same cycle is legal; there is no bubble.
- Group start: the first accepted beat after reset or after a group-end beat latches size_out (0 -> 1) and mode. These ride down the pipeline with the beat; mid-group changes on the inputs are ignored.
- Lane tree: log2(LANES) registered stages, pairwise combine per mode.
  - Sum widens to ACC_WIDTH, wraps modulo 2^ACC_WIDTH.
  - Min/max are unsigned compare; xor is bitwise, zero-extended.
  - Each stage carries valid, first and last flags.
- Accumulate stage:
  - first beat: acc = tree result.
  - otherwise: acc = op(acc, tree result).
  - Identities are not needed because first overrides.
- Last flag is set on the beat where line count == latched size - 1. On the last beat the accumulate stage loads out_res = combined value and out_cnt = latched size, sets out_valid, and clears the accumulator and counter.
- Latency: LAT = log2(LANES) + 1 cycles. A last beat accepted at edge k gives out_valid=1 after edge k+LAT, plus one cycle per intervening stall cycle. Throughput is one line per cycle when unstalled.
- out_valid deasserts on the edge where out_valid && out_ready, unless a new result loads on that same edge; in that case it stays 1 with the new value.
- Line counter wraps only via group end; CNT_WIDTH overflow is impossible since size ≤ 2^CNT_WIDTH-1.
- A size_out=1 group emits one result per line.

Decomposition:
- Shared package num_accu_pkg:
  - mode encoding constants (ACC_SUM, ACC_MIN, ACC_MAX, ACC_XOR).
  - function lanes_of(CACHE_WIDTH, DATA_WIDTH).
  - function clog2-based LAT.
- One sub-module: num_accu_op, a combinational two-operand ACC_WIDTH combiner selected by mode. It is reused in every tree node and in the accumulate stage.

Test Plan:
- Sum, LANES=16, lane i = i on every line, size_out=3, out_ready=1, back-to-back beats -> out_res=360, out_cnt=3, out_valid exactly 5 cycles after 3rd beat accepted, single cycle wide.
- Min/max: line0 lanes = 100+i, line1 lane 7 = 5, others 200, size 2 -> min mode 5; repeat in max mode -> 200.
- Wrap: all lanes 0xFFFFFFFF, ACC_WIDTH=48, size 2^17 lines -> out_res = (2^17*16*(2^32-1)) mod 2^48 = 0xFFFFFFE00000 (= 2^48 - 2^21).
- Backpressure: two size-1 groups, out_ready=0 for 4 cycles after first out_valid -> in_ready low during stall, first result held unchanged, second result appears after release, no beats lost.
- size_out=0 and mode change mid-group: size_out=0 -> each line is its own result, out_cnt=1. Changing mode/size_out between beats of a size-4 group does not affect that group's result.
- Reset mid-group: rst pulsed after 2 of 4 beats, then a fresh size-2 group of lane value 1 -> out_res=32; no stale partial output.

Source files
------------

// File: rtl/num_accu_pkg.sv
// rtl/num_accu_pkg.sv - shared mode encodings and geometry helpers for num_accu_vec
// Contents:
//   ACC_SUM/ACC_MIN/ACC_MAX/ACC_XOR - 2-bit reduction mode encodings
//   lanes_of(cache_width, data_width) - elements per input line
//   lat_of(lanes) - accepted-beat to result latency in cycles
package num_accu_pkg;

    localparam logic [1:0] ACC_SUM = 2'b00;
    localparam logic [1:0] ACC_MIN = 2'b01;
    localparam logic [1:0] ACC_MAX = 2'b10;
    localparam logic [1:0] ACC_XOR = 2'b11;

    function automatic int lanes_of(input int cache_width, input int data_width);
        return cache_width / data_width;
    endfunction

    // One input capture register, one register per tree level, then the
    // accumulate/output register.
    function automatic int lat_of(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/num_accu_op.sv
// rtl/num_accu_op.sv - combinational two-operand combiner for sum/min/max/xor
// Ports:
//   mode in  2          reduction mode (ACC_SUM/ACC_MIN/ACC_MAX/ACC_XOR)
//   a    in  ACC_WIDTH  first operand
//   b    in  ACC_WIDTH  second operand
//   res  out ACC_WIDTH  combined value; sum wraps, min/max unsigned
module num_accu_op
    import num_accu_pkg::*;
#(
    parameter int ACC_WIDTH = 48
) (
    input  logic [1:0]           mode,
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] res
);

    always_comb begin
        res = a + b;
        case (mode)
            ACC_SUM: res = a + b;
            ACC_MIN: res = (a < b) ? a : b;
            ACC_MAX: res = (a > b) ? a : b;
            ACC_XOR: res = a ^ b;
            default: res = a + b;
        endcase
    end

endmodule

// File: rtl/num_accu_vec.sv
// rtl/num_accu_vec.sv - pipelined per-line lane reduction accumulated across groups of lines
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   size_out  in  CNT_WIDTH   lines per group (0 means 1), sampled on a group's first beat
//   mode      in  2           reduction mode, sampled with size_out
//   in_valid/in_ready/in_data input line stream, LANES elements per line
//   out_valid/out_ready       result handshake, result held until accepted
//   out_res   out ACC_WIDTH   group reduction result
//   out_cnt   out CNT_WIDTH   number of lines reduced into out_res
module num_accu_vec
    import num_accu_pkg::*;
#(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 48,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_WIDTH-1:0]   size_out,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CACHE_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_res,
    output logic [CNT_WIDTH-1:0]   out_cnt
);

    localparam int LANES  = lanes_of(CACHE_WIDTH, DATA_WIDTH);
    localparam int STAGES = $clog2(LANES);
    // Tree kept as a heap: node k combines children 2k+1 and 2k+2, the
    // captured input elements are the leaves LEAF0..NODES-1, the root is 0.
    localparam int NODES  = 2 * LANES - 1;
    localparam int LEAF0  = LANES - 1;

    logic stall;
    logic accept;

    // Group tracking on the input side
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] size_q, size_d;
    logic [1:0]           mode_q, mode_d;
    logic                 first_beat, last_beat;
    logic [CNT_WIDTH-1:0] eff_size, cur_cnt;
    logic [1:0]           eff_mode;

    // Per-stage sideband: index 0 is the input capture stage, STAGES the root
    logic [STAGES:0]                pv_q, pv_d;
    logic [STAGES:0]                pf_q, pf_d;
    logic [STAGES:0]                pl_q, pl_d;
    logic [STAGES:0][1:0]           pm_q, pm_d;
    logic [STAGES:0][CNT_WIDTH-1:0] ps_q, ps_d;

    logic [ACC_WIDTH-1:0] node_q   [NODES];
    logic [ACC_WIDTH-1:0] node_d   [NODES];
    logic [ACC_WIDTH-1:0] node_res [LEAF0];

    // Accumulate / output stage
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_op, combined;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_res_q, out_res_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    // Global stall: a held result freezes every stage at once.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !rst;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q && !rst;
    assign out_res   = rst ? '0 : out_res_q;
    assign out_cnt   = rst ? '0 : out_cnt_q;

    always_comb begin
        first_beat = !busy_q;
        eff_size   = size_q;
        eff_mode   = mode_q;
        cur_cnt    = cnt_q;
        if (first_beat) begin
            eff_size = (size_out == '0) ? CNT_WIDTH'(1) : size_out;
            eff_mode = mode;
            cur_cnt  = '0;
        end
        last_beat = (cur_cnt == eff_size - CNT_WIDTH'(1));

        busy_d = busy_q;
        cnt_d  = cnt_q;
        size_d = size_q;
        mode_d = mode_q;
        if (accept) begin
            busy_d = !last_beat;
            cnt_d  = last_beat ? '0 : cur_cnt + CNT_WIDTH'(1);
            size_d = eff_size;
            mode_d = eff_mode;
        end
    end

    // Each tree node uses the mode carried by the stage it reads from.
    for (genvar k = 0; k < LEAF0; k++) begin : g_node
        localparam int S = STAGES + 1 - $clog2(k + 2);
        num_accu_op #(.ACC_WIDTH(ACC_WIDTH)) u_op (
            .mode (pm_q[S-1]),
            .a    (node_q[2*k+1]),
            .b    (node_q[2*k+2]),
            .res  (node_res[k])
        );
    end

    always_comb begin
        pv_d   = pv_q;
        pf_d   = pf_q;
        pl_d   = pl_q;
        pm_d   = pm_q;
        ps_d   = ps_q;
        node_d = node_q;
        if (!stall) begin
            pv_d[0] = accept;
            pf_d[0] = first_beat;
            pl_d[0] = last_beat;
            pm_d[0] = eff_mode;
            ps_d[0] = eff_size;
            for (int s = 1; s <= STAGES; s++) begin
                pv_d[s] = pv_q[s-1];
                pf_d[s] = pf_q[s-1];
                pl_d[s] = pl_q[s-1];
                pm_d[s] = pm_q[s-1];
                ps_d[s] = ps_q[s-1];
            end
            for (int i = 0; i < LANES; i++) begin
                node_d[LEAF0+i] = ACC_WIDTH'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            end
            for (int k = 0; k < LEAF0; k++) begin
                node_d[k] = node_res[k];
            end
        end
    end

    num_accu_op #(.ACC_WIDTH(ACC_WIDTH)) u_acc_op (
        .mode (pm_q[STAGES]),
        .a    (acc_q),
        .b    (node_q[0]),
        .res  (acc_op)
    );

    always_comb begin
        // The first line of a group overrides whatever the accumulator holds,
        // so no per-mode identity value is needed.
        combined    = pf_q[STAGES] ? node_q[0] : acc_op;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_cnt_d   = out_cnt_q;
        if (!stall) begin
            // Not stalled means either nothing is held or it is being taken now.
            out_valid_d = 1'b0;
            if (pv_q[STAGES]) begin
                if (pl_q[STAGES]) begin
                    out_res_d   = combined;
                    out_cnt_d   = ps_q[STAGES];
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = combined;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            size_q      <= '0;
            mode_q      <= '0;
            pv_q        <= '0;
            pf_q        <= '0;
            pl_q        <= '0;
            pm_q        <= '0;
            ps_q        <= '0;
            node_q      <= '{default: '0};
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            mode_q      <= mode_d;
            pv_q        <= pv_d;
            pf_q        <= pf_d;
            pl_q        <= pl_d;
            pm_q        <= pm_d;
            ps_q        <= ps_d;
            node_q      <= node_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

endmodule
